// File: rtl/rtc_bus_sequencer_pkg.sv
// Package: rtc_bus_sequencer_pkg
// Shared definitions for the RTC bus sequencer and the firmware-facing blocks
// that sit on the same PicoBlaze port bus.
//  - Default PicoBlaze port ids for the sequencer register map
//  - FSM state encodings
//  - CMD and STAT bit positions, plus a helper that packs the STAT byte
package rtc_bus_sequencer_pkg;

    // Default port map.
    localparam logic [7:0] DEF_PORT_ADDR  = 8'h01;
    localparam logic [7:0] DEF_PORT_DATA  = 8'h02;
    localparam logic [7:0] DEF_PORT_CMD   = 8'h03;
    localparam logic [7:0] DEF_PORT_STAT  = 8'h04;
    localparam logic [7:0] DEF_PORT_RDATA = 8'h05;

    // Bus-cycle FSM encodings.
    localparam int unsigned STATE_W    = 3;
    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_A_PULSE = 3'd1;
    localparam logic [2:0]  ST_A_GAP   = 3'd2;
    localparam logic [2:0]  ST_D_PULSE = 3'd3;
    localparam logic [2:0]  ST_D_GAP   = 3'd4;

    // CMD register bits.
    localparam int unsigned CMD_START_BIT = 0;
    localparam int unsigned CMD_READ_BIT  = 1;

    // STAT register bits.
    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_DONE_BIT    = 1;
    localparam int unsigned STAT_OVERRUN_BIT = 2;

    // Pin bundle driven by the FSM output decode.
    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic ad_sel;
        logic ad_oe;
    } rtc_pins_t;

    localparam rtc_pins_t PINS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                        ad_sel: 1'b1, ad_oe: 1'b0};

    function automatic logic [7:0] stat_byte(input logic overrun, input logic done,
                                             input logic busy);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_OVERRUN_BIT] = overrun;
        s[STAT_DONE_BIT]    = done;
        s[STAT_BUSY_BIT]    = busy;
        return s;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Module: rtc_bus_sequencer_phase_timer
// Down-counter that times one bus phase. Loading value N makes 'expired' rise
// N cycles later, so loading (length - 1) gives a phase of exactly 'length' cycles.
// Ports:
//  clk         in   system clock
//  reset       in   synchronous active-high reset
//  load        in   reload the counter with load_value
//  load_value  in   8-bit reload value
//  expired     out  high while the count is zero
module rtc_bus_sequencer_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       expired
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'h00;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != 8'h00) begin
            cnt_q <= cnt_q - 8'h01;
        end
    end

    assign expired = (cnt_q == 8'h00);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Module: rtc_bus_sequencer
// PicoBlaze I/O-port slave that runs complete address-then-data cycles on the
// external RTC's multiplexed A/D bus. Firmware loads ADDR/DATA, writes CMD,
// polls STAT and reads RDATA; all pin timing is generated here.
// Ports:
//  clk, reset                         clock and synchronous active-high reset
//  port_id, write_strobe, out_port    kcpsm3 output port bus
//  read_strobe                        kcpsm3 input strobe (not needed internally)
//  in_port                            read mux on port_id (STAT, RDATA, else 0)
//  rtc_ad_in                          A/D bus read-back from the top-level tristate
//  rtc_ad_out, rtc_ad_oe              A/D bus drive value and enable
//  rtc_ad_sel                         0 = address phase, 1 = data phase
//  rtc_cs_n, rtc_rd_n, rtc_wr_n       active-low RTC strobes
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int unsigned T_PULSE    = 10,
    parameter int unsigned T_GAP      = 5,
    parameter logic [7:0]  PORT_ADDR  = DEF_PORT_ADDR,
    parameter logic [7:0]  PORT_DATA  = DEF_PORT_DATA,
    parameter logic [7:0]  PORT_CMD   = DEF_PORT_CMD,
    parameter logic [7:0]  PORT_STAT  = DEF_PORT_STAT,
    parameter logic [7:0]  PORT_RDATA = DEF_PORT_RDATA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    input  logic [7:0] rtc_ad_in,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    output logic       rtc_ad_sel,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n
);

    // Timer reload values: a phase of length L loads L-1.
    localparam logic [7:0] PULSE_LOAD = 8'(T_PULSE - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(T_GAP - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         addr_q, data_q;
    logic [7:0]         addr_sh_q, data_sh_q;
    logic [7:0]         rdata_q;
    logic               rw_q;
    logic               busy_q, done_q, overrun_q;

    logic               tmr_load;
    logic [7:0]         tmr_value;
    logic               tmr_expired;

    logic               addr_write, data_write, cmd_start, cmd_accept;
    logic               cycle_end, read_sample;
    rtc_pins_t          pins;

    // The kcpsm3 input strobe carries no information this block needs.
    logic               unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    assign addr_write = write_strobe && (port_id == PORT_ADDR);
    assign data_write = write_strobe && (port_id == PORT_DATA);
    assign cmd_start  = write_strobe && (port_id == PORT_CMD) && out_port[CMD_START_BIT];
    assign cmd_accept = cmd_start && (state_q == ST_IDLE);

    assign cycle_end   = (state_q == ST_D_GAP) && tmr_expired;
    assign read_sample = (state_q == ST_D_PULSE) && tmr_expired && rw_q;

    rtc_bus_sequencer_phase_timer u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

    // Next-state logic; the timer is reloaded on every state entry.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = PULSE_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d   = ST_A_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = PULSE_LOAD;
                end
            end
            ST_A_PULSE: begin
                if (tmr_expired) begin
                    state_d   = ST_A_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
            end
            ST_A_GAP: begin
                if (tmr_expired) begin
                    state_d   = ST_D_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = PULSE_LOAD;
                end
            end
            ST_D_PULSE: begin
                if (tmr_expired) begin
                    state_d   = ST_D_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
            end
            ST_D_GAP: begin
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            addr_sh_q <= 8'h00;
            data_sh_q <= 8'h00;
            rdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (addr_write) begin
                addr_q <= out_port;
            end
            if (data_write) begin
                data_q <= out_port;
            end

            // Shadows decouple the running cycle from later ADDR/DATA writes.
            if (cmd_accept) begin
                addr_sh_q <= addr_q;
                data_sh_q <= data_q;
                rw_q      <= out_port[CMD_READ_BIT];
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else if (cmd_start) begin
                overrun_q <= 1'b1;
            end

            if (cycle_end) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end

            if (read_sample) begin
                rdata_q <= rtc_ad_in;
            end
        end
    end

    // Pin decode straight from the state register, so a reset returns the
    // pins to idle on the same edge that clears the FSM.
    always_comb begin
        pins       = PINS_IDLE;
        rtc_ad_out = 8'h00;
        case (state_q)
            ST_A_PULSE: begin
                pins.cs_n   = 1'b0;
                pins.wr_n   = 1'b0;
                pins.ad_sel = 1'b0;
                pins.ad_oe  = 1'b1;
                rtc_ad_out  = addr_sh_q;
            end
            ST_A_GAP: begin
                // Address stays on the bus through the gap.
                pins.ad_sel = 1'b0;
                pins.ad_oe  = 1'b1;
                rtc_ad_out  = addr_sh_q;
            end
            ST_D_PULSE: begin
                pins.cs_n = 1'b0;
                if (rw_q) begin
                    pins.rd_n = 1'b0;
                end else begin
                    pins.wr_n  = 1'b0;
                    pins.ad_oe = 1'b1;
                    rtc_ad_out = data_sh_q;
                end
            end
            default: begin
                pins = PINS_IDLE;
            end
        endcase
    end

    assign rtc_cs_n   = pins.cs_n;
    assign rtc_rd_n   = pins.rd_n;
    assign rtc_wr_n   = pins.wr_n;
    assign rtc_ad_sel = pins.ad_sel;
    assign rtc_ad_oe  = pins.ad_oe;

    always_comb begin
        in_port = 8'h00;
        if (port_id == PORT_STAT) begin
            in_port = stat_byte(overrun_q, done_q, busy_q);
        end else if (port_id == PORT_RDATA) begin
            in_port = rdata_q;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench: tb_rtc_bus_sequencer
// Directed stimulus pushes expected port reads, bus phases and busy lengths into
// queues; independent monitors observe the DUT and pop/compare.
module tb_rtc_bus_sequencer;
    import rtc_bus_sequencer_pkg::*;

    localparam int unsigned TP = 4;
    localparam int unsigned TG = 2;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic [7:0] rtc_ad_in;
    logic [7:0] rtc_ad_out;
    logic       rtc_ad_oe;
    logic       rtc_ad_sel;
    logic       rtc_cs_n;
    logic       rtc_rd_n;
    logic       rtc_wr_n;
    logic       chk_en;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         gap;   // -1 = don't care
        int         len;
        logic       sel;
        logic       wr_n;
        logic       rd_n;
        logic       oe;
        logic [7:0] ad;    // compared only when oe is expected high
    } phase_t;

    phase_t     phase_q[$];
    logic [7:0] rd_exp_q[$];
    string      rd_name_q[$];
    int         lat_q[$];

    rtc_bus_sequencer #(
        .T_PULSE (TP),
        .T_GAP   (TG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .rtc_ad_in    (rtc_ad_in),
        .rtc_ad_out   (rtc_ad_out),
        .rtc_ad_oe    (rtc_ad_oe),
        .rtc_ad_sel   (rtc_ad_sel),
        .rtc_cs_n     (rtc_cs_n),
        .rtc_rd_n     (rtc_rd_n),
        .rtc_wr_n     (rtc_wr_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_phase(input int gap, input int len, input logic sel,
                              input logic wr_n, input logic rd_n, input logic oe,
                              input logic [7:0] ad);
        phase_t p;
        p.gap  = gap;
        p.len  = len;
        p.sel  = sel;
        p.wr_n = wr_n;
        p.rd_n = rd_n;
        p.oe   = oe;
        p.ad   = ad;
        phase_q.push_back(p);
    endtask

    // All bus tasks enter and leave 1 time unit after a rising edge.
    task automatic wr(input logic [7:0] port, input logic [7:0] val);
        port_id      = port;
        out_port     = val;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] port, input logic [7:0] exp);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        port_id     = port;
        read_strobe = 1'b1;
        chk_en      = 1'b1;
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
        chk_en      = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic poll_n(input int n);
        port_id     = DEF_PORT_STAT;
        read_strobe = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    // Polls STAT until busy reads low; the first idle cycle is also polled.
    task automatic poll_idle(input string name);
        int n;
        n           = 0;
        port_id     = DEF_PORT_STAT;
        read_strobe = 1'b1;
        #1;
        while (in_port[STAT_BUSY_BIT] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            check({name, "_timeout"}, n, 0);
        end
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    // Port read monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (read_strobe && chk_en) begin
                if (rd_exp_q.size() == 0) begin
                    check("rd_unexpected", int'(in_port), -1);
                end else begin
                    check(rd_name_q.pop_front(), int'(in_port), int'(rd_exp_q.pop_front()));
                end
            end
        end
    end

    // Busy-length monitor: measured from the first polled busy cycle to the
    // first polled idle cycle, counting unpolled cycles in between.
    initial begin
        bit in_run;
        int run_len;
        bit polled;
        in_run  = 1'b0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_run  = 1'b0;
                run_len = 0;
            end else begin
                polled = read_strobe && (port_id == DEF_PORT_STAT);
                if (in_run) begin
                    if (polled && !in_port[STAT_BUSY_BIT]) begin
                        in_run = 1'b0;
                        if (lat_q.size() == 0) begin
                            check("busy_unexpected", run_len, -1);
                        end else begin
                            check("busy_cycles", run_len, lat_q.pop_front());
                        end
                    end else begin
                        run_len++;
                    end
                end else if (polled && in_port[STAT_BUSY_BIT]) begin
                    in_run  = 1'b1;
                    run_len = 1;
                end
            end
        end
    end

    // Bus-phase monitor: one record per cs_n low pulse.
    initial begin
        int         low_len;
        int         hi_len;
        int         cur_gap;
        bit         stable;
        logic       c_sel, c_wr, c_rd, c_oe;
        logic [7:0] c_ad;
        phase_t     e;
        low_len = 0;
        hi_len  = 0;
        cur_gap = 0;
        stable  = 1'b1;
        c_sel   = 1'b0;
        c_wr    = 1'b1;
        c_rd    = 1'b1;
        c_oe    = 1'b0;
        c_ad    = 8'h00;
        forever begin
            @(negedge clk);
            if (!rtc_cs_n) begin
                if (low_len == 0) begin
                    cur_gap = hi_len;
                    stable  = 1'b1;
                    c_sel   = rtc_ad_sel;
                    c_wr    = rtc_wr_n;
                    c_rd    = rtc_rd_n;
                    c_oe    = rtc_ad_oe;
                    c_ad    = rtc_ad_out;
                end else if (c_sel != rtc_ad_sel || c_wr != rtc_wr_n || c_rd != rtc_rd_n ||
                             c_oe != rtc_ad_oe || (c_oe && c_ad != rtc_ad_out)) begin
                    stable = 1'b0;
                end
                if ((!rtc_rd_n && !rtc_wr_n) || (!rtc_rd_n && rtc_ad_oe)) begin
                    stable = 1'b0;
                end
                low_len++;
            end else begin
                if (low_len > 0) begin
                    if (phase_q.size() == 0) begin
                        check("phase_unexpected", low_len, -1);
                    end else begin
                        e = phase_q.pop_front();
                        check("phase_len", low_len, e.len);
                        if (e.gap >= 0) check("phase_gap", cur_gap, e.gap);
                        check("phase_ad_sel", int'(c_sel), int'(e.sel));
                        check("phase_wr_n", int'(c_wr), int'(e.wr_n));
                        check("phase_rd_n", int'(c_rd), int'(e.rd_n));
                        check("phase_oe", int'(c_oe), int'(e.oe));
                        if (e.oe) check("phase_ad_out", int'(c_ad), int'(e.ad));
                        check("phase_stable", int'(stable), 1);
                    end
                    low_len = 0;
                    hi_len  = 0;
                end
                hi_len++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        port_id      = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        out_port     = 8'h00;
        rtc_ad_in    = 8'h37;
        chk_en       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst_cs_n", int'(rtc_cs_n), 1);
        check("rst_rd_n", int'(rtc_rd_n), 1);
        check("rst_wr_n", int'(rtc_wr_n), 1);
        check("rst_ad_sel", int'(rtc_ad_sel), 1);
        check("rst_ad_oe", int'(rtc_ad_oe), 0);
        check("rst_ad_out", int'(rtc_ad_out), 0);
        rd_chk("rst_stat", DEF_PORT_STAT, 8'h00);
        rd_chk("rst_rdata", DEF_PORT_RDATA, 8'h00);

        // 1: write cycle.
        wr(DEF_PORT_ADDR, 8'h21);
        wr(DEF_PORT_DATA, 8'h45);
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21);
        push_phase(TG, TP, 1'b1, 1'b0, 1'b1, 1'b1, 8'h45);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h01);
        poll_idle("t1");
        rd_chk("t1_stat", DEF_PORT_STAT, 8'h02);

        // 2: read cycle.
        wr(DEF_PORT_ADDR, 8'h22);
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
        push_phase(TG, TP, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h03);
        poll_idle("t2");
        rd_chk("t2_rdata", DEF_PORT_RDATA, 8'h37);
        rd_chk("t2_stat", DEF_PORT_STAT, 8'h02);

        // 3: command during A_GAP is ignored and flags overrun.
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
        push_phase(TG, TP, 1'b1, 1'b0, 1'b1, 1'b1, 8'h45);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h01);
        poll_n(TP);
        wr(DEF_PORT_CMD, 8'h01);
        rd_chk("t3_stat_busy", DEF_PORT_STAT, 8'h05);
        poll_idle("t3");
        rd_chk("t3_stat_end", DEF_PORT_STAT, 8'h06);

        // 4: ADDR write during D_PULSE only affects the next command.
        wr(DEF_PORT_ADDR, 8'h21);
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21);
        push_phase(TG, TP, 1'b1, 1'b0, 1'b1, 1'b1, 8'h45);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h01);
        poll_n(TP + TG);
        wr(DEF_PORT_ADDR, 8'hAA);
        poll_idle("t4a");
        rd_chk("t4a_stat", DEF_PORT_STAT, 8'h02);
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        push_phase(TG, TP, 1'b1, 1'b0, 1'b1, 1'b1, 8'h45);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h01);
        poll_idle("t4b");
        rd_chk("t4b_stat", DEF_PORT_STAT, 8'h02);

        // 5: one-cycle reset in the third D_PULSE cycle of a read.
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
        push_phase(TG, 3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        wr(DEF_PORT_CMD, 8'h03);
        repeat (TP + TG + 2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_cs_n", int'(rtc_cs_n), 1);
        check("t5_rd_n", int'(rtc_rd_n), 1);
        check("t5_wr_n", int'(rtc_wr_n), 1);
        check("t5_ad_oe", int'(rtc_ad_oe), 0);
        rd_chk("t5_stat", DEF_PORT_STAT, 8'h00);
        rd_chk("t5_rdata", DEF_PORT_RDATA, 8'h00);

        // 6: unmapped port, then back-to-back commands.
        rd_chk("t6_port7f", 8'h7F, 8'h00);
        rd_chk("t6_port_addr", DEF_PORT_ADDR, 8'h00);
        rtc_ad_in = 8'h5A;
        wr(DEF_PORT_ADDR, 8'h33);
        wr(DEF_PORT_DATA, 8'h44);
        push_phase(-1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        push_phase(TG, TP, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44);
        // D_GAP plus the single idle cycle in which the second command lands.
        push_phase(TG + 1, TP, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        push_phase(TG, TP, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        lat_q.push_back(2 * (TP + TG));
        wr(DEF_PORT_CMD, 8'h01);
        repeat (2 * (TP + TG)) begin
            @(posedge clk);
            #1;
        end
        wr(DEF_PORT_CMD, 8'h03);
        poll_idle("t6");
        rd_chk("t6_rdata", DEF_PORT_RDATA, 8'h5A);
        rd_chk("t6_stat", DEF_PORT_STAT, 8'h02);

        repeat (4) @(posedge clk);
        #1;
        check("phase_q_empty", phase_q.size(), 0);
        check("rd_q_empty", rd_exp_q.size(), 0);
        check("lat_q_empty", lat_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
